sprite_rom_arbiter: RTL

Shares one synchronous sprite ROM between the on-screen character requesters (Fireboy, Watergirl, overlay/HUD) so the design instantiates a single ROM instead of one per character. Each requester presents a ROM address with a request and receives a one-hot tagged read-data return a fixed number of cycles later. Arbitration is round-robin with an optional bounded lock, so a requester can stream a contiguous sprite row. The block sits between the per-character motion/pixel modules and the sprite ROM, ahead of the colour mapper.

---
 rtl/sprite_rom_arbiter_pkg.sv | 16 +
 rtl/sprite_rom_arbiter_if.sv | 29 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 33 +++
 rtl/sprite_rom_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and defaults for the sprite ROM arbiter slice.
package sprite_pkg;

  localparam int NUM_REQ_DEFAULT = 3;
  localparam int ADDR_W_DEFAULT  = 12;

  localparam int REQ_FIREBOY   = 0;
  localparam int REQ_WATERGIRL = 1;
  localparam int REQ_OVERLAY   = 2;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester and ROM-side signal bundle of the sprite ROM arbiter.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_rdata;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;

  modport master (
    output req, lock, addr, rom_rdata,
    input  gnt, rom_addr, rd_valid, rd_data
  );

  modport slave (
    input  req, lock, addr, rom_rdata,
    output gnt, rom_addr, rd_valid, rd_data
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, skipping excluded ones.
module rr_pick
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand] && !excl[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among the character requesters with
// round-robin arbitration, bounded lock bursts and a tagged return path.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = 4,
  parameter int ROM_LAT   = 2,
  parameter int MAX_BURST = 64
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [BCNT_W-1:0]  bcnt, bcnt_n;
  logic [NUM_REQ-1:0] vpipe [ROM_LAT];

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] excl;
  logic               hold;
  logic               saturated;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0]  rom_addr;

  // Owner is only excluded on a saturated release if someone else is waiting;
  // ptr already sits at owner+1, so the owner is otherwise scanned last.
  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner == PTR_W'(i));
    end
    hold      = (state == LOCKED) && (|(bus.req & bus.lock & owner_oh))
                && (bcnt < BCNT_W'(MAX_BURST));
    saturated = (state == LOCKED) && (bcnt == BCNT_W'(MAX_BURST));
    excl      = (saturated && (|(bus.req & ~owner_oh))) ? owner_oh : '0;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .excl (excl),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    state_n = ARB;
    ptr_n   = ptr;
    owner_n = owner;
    bcnt_n  = '0;
    gnt     = '0;
    if (hold) begin
      gnt     = owner_oh;
      state_n = LOCKED;
      bcnt_n  = bcnt + 1'b1;
    end else if (|pick_gnt) begin
      gnt   = pick_gnt;
      ptr_n = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      if (|(bus.lock & pick_gnt)) begin
        state_n = LOCKED;
        owner_n = pick_idx;
        bcnt_n  = BCNT_W'(1);
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rom_addr = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      bcnt  <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) vpipe[k] <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      bcnt     <= bcnt_n;
      vpipe[0] <= gnt;
      for (int unsigned k = 1; k < ROM_LAT; k++) vpipe[k] <= vpipe[k-1];
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rom_addr = rom_addr;
  assign bus.rd_valid = vpipe[ROM_LAT-1];
  assign bus.rd_data  = DATA_W'(bus.rom_rdata);

endmodule
